// File: rtl/serial_pattern_tx_pkg.sv
// Shared definitions for the lab2 serial pattern transmitter.
package serial_pattern_tx_pkg;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;
  localparam logic       IDLE_LEVEL_DEF = 1'b0;
endpackage

// File: rtl/tx_hold_buf.sv
// One-entry valid/ready holding register in front of the shifter.
module tx_hold_buf
  import serial_pattern_tx_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_take
);
  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  // ready is only ever !full, so accept and take can never coincide
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (in_valid && !full_q) begin
      full_d = 1'b1;
      data_d = in_data;
    end else if (out_take) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign in_ready  = !full_q;
  assign out_data  = data_q;
  assign out_valid = full_q;
endmodule

// File: rtl/serial_pattern_tx.sv
// Parallel-to-serial pattern source for the lab2 detector's X input.
module serial_pattern_tx
  import serial_pattern_tx_pkg::*;
#(
  parameter int   WIDTH      = 4,
  parameter int   BIT_CYCLES = 1,
  parameter int   MSB_FIRST  = 0,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             X,
  output logic             first,
  output logic             busy,
  output logic             word_done
);
  localparam int BCW = $clog2(WIDTH);
  localparam int PW  = $clog2(BIT_CYCLES) + 1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             x_q, x_d, first_q, first_d, done_q, done_d;
  logic [WIDTH-1:0] hold_data;
  logic             hold_full, load, last_pre, last_bit;

  tx_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (hold_data),
    .out_valid(hold_full),
    .out_take (load)
  );

  function automatic logic lead_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
  endfunction

  assign last_pre = (pre_q == PW'(BIT_CYCLES - 1));
  assign last_bit = (bit_cnt_q == BCW'(WIDTH - 1));

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    pre_d     = pre_q;
    x_d       = x_q;
    first_d   = first_q;
    done_d    = 1'b0;
    load      = 1'b0;
    if (state_q == ST_IDLE) begin
      x_d     = IDLE_LEVEL;
      first_d = 1'b0;
      load    = hold_full;
    end else if (!last_pre) begin
      pre_d = pre_q + 1'b1;
    end else if (!last_bit) begin
      pre_d     = '0;
      bit_cnt_d = bit_cnt_q + 1'b1;
      shift_d   = advance(shift_q);
      x_d       = lead_bit(advance(shift_q));
      first_d   = 1'b0;
    end else begin
      // word boundary: chain straight into a held word, else drop to idle
      done_d  = 1'b1;
      load    = hold_full;
      state_d = ST_IDLE;
      x_d     = IDLE_LEVEL;
      first_d = 1'b0;
    end
    if (load) begin
      state_d   = ST_SHIFT;
      shift_d   = hold_data;
      x_d       = lead_bit(hold_data);
      first_d   = 1'b1;
      bit_cnt_d = '0;
      pre_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      pre_q     <= '0;
      x_q       <= IDLE_LEVEL;
      first_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      pre_q     <= pre_d;
      x_q       <= x_d;
      first_q   <= first_d;
      done_q    <= done_d;
    end
  end

  assign X         = x_q;
  assign first     = first_q;
  assign busy      = (state_q == ST_SHIFT);
  assign word_done = done_q;
endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench: two transmitter configurations sharing clock, reset and data.
module tb_serial_pattern_tx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] in_data = 4'b0;
  logic       in_valid_a = 1'b0, in_valid_b = 1'b0;
  logic       rdy_a, x_a, first_a, busy_a, wd_a;
  logic       rdy_b, x_b, first_b, busy_b, wd_b;
  logic       acc;
  int         n_chk = 0, n_pass = 0;
  int         wi;
  logic [3:0] w3 [3] = '{4'b1101, 4'b0011, 4'b1011};
  logic       e3 [12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic       e6 [8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic       e2 [4]  = '{1'b1, 1'b0, 1'b1, 1'b1};

  always #5 clk = ~clk;

  serial_pattern_tx #(.WIDTH(4), .BIT_CYCLES(1), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid_a), .in_ready(rdy_a),
    .X(x_a), .first(first_a), .busy(busy_a), .word_done(wd_a));

  serial_pattern_tx #(.WIDTH(4), .BIT_CYCLES(3), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid_b), .in_ready(rdy_b),
    .X(x_b), .first(first_b), .busy(busy_b), .word_done(wd_b));

  task automatic tick();
    acc = (in_valid_a && rdy_a) || (in_valid_b && rdy_b);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    // 1: reset and idle
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t1_x", x_a, 0); chk("t1_busy", busy_a, 0);
      chk("t1_rdy", rdy_a, 1); chk("t1_wd", wd_a, 0);
      chk("t1_rdy_b", rdy_b, 1); chk("t1_x_b", x_b, 0);
    end

    // 2: single word, LSB first
    in_data = 4'b1101; in_valid_a = 1'b1;
    tick();
    chk("t2_acc", acc, 1); chk("t2_rdy_full", rdy_a, 0); chk("t2_x_pre", x_a, 0);
    in_valid_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_x", x_a, e2[i]); chk("t2_first", first_a, i == 0);
      chk("t2_busy", busy_a, 1); chk("t2_wd", wd_a, 0);
    end
    tick();
    chk("t2_done", wd_a, 1); chk("t2_x_idle", x_a, 0); chk("t2_busy_end", busy_a, 0);
    tick();
    chk("t2_done_pulse", wd_a, 0);

    // 3: back-to-back stream
    wi = 0; in_data = w3[0]; in_valid_a = 1'b1;
    tick();
    chk("t3_acc0", acc, 1);
    wi++; in_data = w3[wi];
    for (int i = 0; i < 12; i++) begin
      tick();
      if (acc) begin
        wi++;
        if (wi < 3) in_data = w3[wi];
        else in_valid_a = 1'b0;
      end
      chk("t3_x", x_a, e3[i]); chk("t3_first", first_a, (i % 4) == 0);
      chk("t3_wd", wd_a, (i == 4) || (i == 8)); chk("t3_busy", busy_a, 1);
    end
    tick();
    chk("t3_done", wd_a, 1); chk("t3_x_idle", x_a, 0);
    chk("t3_busy_end", busy_a, 0); chk("t3_all_acc", wi, 3);

    // 4: BIT_CYCLES=3, MSB first
    in_data = 4'b1000; in_valid_b = 1'b1;
    tick();
    chk("t4_acc", acc, 1);
    in_valid_b = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("t4_x", x_b, i < 3); chk("t4_first", first_b, i < 3);
      chk("t4_wd", wd_b, 0); chk("t4_busy", busy_b, 1);
    end
    tick();
    chk("t4_done", wd_b, 1); chk("t4_x_idle", x_b, 0); chk("t4_busy_end", busy_b, 0);
    tick();
    chk("t4_done_pulse", wd_b, 0);

    // 5: reset mid-word with a word held
    in_data = 4'b1111; in_valid_a = 1'b1;
    tick();
    chk("t5_acc0", acc, 1);
    in_data = 4'b0101;
    tick();
    chk("t5_nacc", acc, 0); chk("t5_x0", x_a, 1);
    tick();
    chk("t5_acc1", acc, 1); chk("t5_x1", x_a, 1);
    in_valid_a = 1'b0;
    tick();
    chk("t5_x2", x_a, 1); chk("t5_held", rdy_a, 0);
    rst_n = 1'b0;
    tick();
    chk("t5_rst_x", x_a, 0); chk("t5_rst_wd", wd_a, 0);
    chk("t5_rst_rdy", rdy_a, 1); chk("t5_rst_busy", busy_a, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t5_quiet_x", x_a, 0); chk("t5_quiet_wd", wd_a, 0); chk("t5_quiet_busy", busy_a, 0);
    end

    // 6: data changing while not ready is ignored
    in_data = 4'b0110; in_valid_a = 1'b1;
    tick();
    chk("t6_acc0", acc, 1);
    in_data = 4'b1111;
    tick();
    chk("t6_nacc0", acc, 0); chk("t6_x", x_a, e6[0]);
    in_data = 4'b1001;
    tick();
    chk("t6_acc1", acc, 1); chk("t6_x", x_a, e6[1]);
    in_data = 4'b0000;
    for (int i = 2; i < 8; i++) begin
      tick();
      if (i < 5) chk("t6_nacc", acc, 0);
      if (i == 4) in_valid_a = 1'b0;
      chk("t6_x", x_a, e6[i]); chk("t6_wd", wd_a, i == 4);
    end
    tick();
    chk("t6_done", wd_a, 1); chk("t6_x_idle", x_a, 0); chk("t6_busy_end", busy_a, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
